// File: rtl/oct_event_counter.sv
// oct_event_counter
//   Debounced push-button event counter producing DIGITS octal digit codes
//   (3 bits each, digit 0 least significant) for the seven-segment decode
//   stage. Each button is synchronised (s1 -> s2) and then filtered to f;
//   a rising edge of the filtered increment level adds 1 in base 8 when en=1.
//   The filtered clear level forces the count to 0 and has priority.
//
//   Build option: define OCT_CNT_DEBOUNCE_EN to build the debounce filter.
//   When undefined, f is a plain register of s2 and DB_CYCLES is not used.
//
//   Button index 0 is increment, index 1 is clear in all 2-bit vectors.
module oct_event_counter #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                btn_inc,
  input  logic                btn_clr,
  output logic [3*DIGITS-1:0] digits,
  output logic                ovf,
  output logic                inc_ack
);

  localparam int unsigned BTN_INC = 0;
  localparam int unsigned BTN_CLR = 1;

  // Elaboration-time parameter range checks.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("oct_event_counter: DIGITS must be in 1..8");
  end
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("oct_event_counter: DB_CYCLES must be >= 2");
  end

  // Synchroniser and filter state, one bit per button.
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] f_q,  f_d;

  // Registered copy of the filtered increment level for edge detection.
  logic inc_prev_q, inc_prev_d;

  // Count and output pulses.
  logic [3*DIGITS-1:0] digits_q, digits_d;
  logic                ovf_q,    ovf_d;
  logic                inc_ack_q, inc_ack_d;

  // Combinational helpers for the count update.
  logic                inc_evt;
  logic [3*DIGITS-1:0] digits_plus1;
  logic                carry_out;

  // Two-flop synchroniser for both raw button inputs.
  always_comb begin
    s1_d = {btn_clr, btn_inc};
    s2_d = s1_q;
  end

`ifdef OCT_CNT_DEBOUNCE_EN
  localparam int unsigned DBC_W = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);

  logic [1:0][DBC_W-1:0] dbc_q, dbc_d;

  // Debounce filter: f follows s2 only after s2 has differed from f for
  // DB_CYCLES-1 consecutive samples; the compare is on the value dbc is
  // about to take, so f changes DB_CYCLES edges after s1 first sees the new
  // level. Any sample with s2 == f restarts the count.
  always_comb begin
    f_d   = f_q;
    dbc_d = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      if (s2_q[b] != f_q[b]) begin
        if (dbc_q[b] == DBC_W'(DB_CYCLES - 2)) begin
          f_d[b]   = s2_q[b];
          dbc_d[b] = '0;
        end else begin
          dbc_d[b] = dbc_q[b] + DBC_W'(1);
        end
      end
    end
  end

  // Debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbc_q <= '0;
    end else begin
      dbc_q <= dbc_d;
    end
  end
`else
  // Filter removed: f is a third register stage behind s2.
  always_comb begin
    f_d = s2_q;
  end
`endif

  // Rising-edge detect on the filtered increment level.
  always_comb begin
    inc_prev_d = f_q[BTN_INC];
    inc_evt    = f_q[BTN_INC] & ~inc_prev_q;
  end

  // Base-8 increment with the carry rippling through every digit in one
  // cycle; carry_out is set only when every digit was 7.
  always_comb begin
    digits_plus1 = digits_q;
    carry_out    = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry_out) begin
        if (digits_q[3*i +: 3] == 3'd7) begin
          digits_plus1[3*i +: 3] = 3'd0;
        end else begin
          digits_plus1[3*i +: 3] = digits_q[3*i +: 3] + 3'd1;
          carry_out              = 1'b0;
        end
      end
    end
  end

  // Count update: clear beats increment (the event is dropped), else an
  // enabled event increments, else hold.
  always_comb begin
    digits_d  = digits_q;
    ovf_d     = 1'b0;
    inc_ack_d = 1'b0;
    if (f_q[BTN_CLR]) begin
      digits_d = '0;
    end else if (inc_evt && en) begin
      digits_d  = digits_plus1;
      inc_ack_d = 1'b1;
      ovf_d     = carry_out;
    end
  end

  // State registers for synchroniser, filter outputs, edge detect and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      f_q        <= '0;
      inc_prev_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      inc_ack_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      f_q        <= f_d;
      inc_prev_q <= inc_prev_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      inc_ack_q  <= inc_ack_d;
    end
  end

  assign digits  = digits_q;
  assign ovf     = ovf_q;
  assign inc_ack = inc_ack_q;

endmodule

// File: tb/tb_oct_event_counter.sv
// Scoreboard bench for oct_event_counter with DIGITS=2, DB_CYCLES=4.
// Stimulus pushes the expected (digits, ovf, inc_ack, edge) for every output
// change it causes; a negedge monitor pops one entry whenever the DUT shows
// inc_ack or a change of digits.
module tb_oct_event_counter;

  localparam int DIGITS = 2;
  localparam int DB     = 4;
`ifdef OCT_CNT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = DB + 1;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 3;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b1;
  logic                btn_inc = 1'b0;
  logic                btn_clr = 1'b0;
  logic [3*DIGITS-1:0] digits;
  logic                ovf;
  logic                inc_ack;

  typedef struct {
    logic [5:0] dig;
    logic       ovf;
    logic       ack;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model = 0;
  logic [5:0] prev_dig = '0;

  oct_event_counter #(.DIGITS(DIGITS), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .btn_inc (btn_inc),
    .btn_clr (btn_clr),
    .digits  (digits),
    .ovf     (ovf),
    .inc_ack (inc_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit, queue=%0d expected 0", q.size());
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every visible output event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inc_ack || (digits != prev_dig)) begin
        if (q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_event: digits=%o ovf=%0b inc_ack=%0b, expected no event, edge %0d",
                   digits, ovf, inc_ack, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ev_digits", int'(digits), int'(e.dig));
          chk("ev_ovf", int'(ovf), int'(e.ovf));
          chk("ev_inc_ack", int'(inc_ack), int'(e.ack));
          chk("ev_edge", cyc, e.cyc);
        end
      end else begin
        chk("ovf_idle", int'(ovf), 0);
      end
    end
    prev_dig = digits;
  end

  task automatic push(input logic [5:0] dig, input logic o, input logic a, input int c);
    exp_t e;
    e.dig = dig; e.ovf = o; e.ack = a; e.cyc = c;
    q.push_back(e);
  endtask

  // Drive buttons from a negedge; the following posedge is edge N.
  task automatic press(input bit inc, input bit clr, input int hold, input int gap,
                       input bit do_push, input logic [5:0] dig,
                       input logic o, input logic a);
    @(negedge clk);
    btn_inc = inc;
    btn_clr = clr;
    if (do_push) push(dig, o, a, cyc + 1 + LAT);
    repeat (hold) @(negedge clk);
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_inc();
    model = (model + 1) % 64;
    press(1'b1, 1'b0, DB + 2, DB + 2, 1'b1, 6'(model), model == 0, 1'b1);
  endtask

  initial begin
    // Reset with buttons toggling randomly.
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      btn_inc = 1'($urandom);
      btn_clr = 1'($urandom);
      if (i % 4 == 3) begin
        chk("rst_digits", int'(digits), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_inc_ack", int'(inc_ack), 0);
      end
    end
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_digits", int'(digits), 0);

    // Single clean press held 10 cycles: 0o01 at N+LAT.
    model = 1;
    press(1'b1, 1'b0, 10, 10, 1'b1, 6'o01, 1'b0, 1'b1);
    chk("single_digits", int'(digits), 6'o01);

    // Bounce: 2 cycles high, 2 low, 20 cycles.
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      btn_inc = ((i % 4) < 2);
      if (!DEB && (i % 4 == 0)) begin
        model = model + 1;
        push(6'(model), 1'b0, 1'b1, cyc + 1 + LAT);
      end
      @(negedge clk);
    end
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_digits", int'(digits), DEB ? 6'o01 : 6'o06);

    // Clear back to zero.
    model = 0;
    press(1'b0, 1'b1, DB + 2, DB + 2, 1'b1, 6'o00, 1'b0, 1'b0);
    chk("clear_digits", int'(digits), 0);

    // 63 presses to 0o77, then the wrapping press.
    for (int i = 0; i < 63; i++) press_inc();
    chk("carry_77", int'(digits), 6'o77);
    chk("carry_77_ovf", int'(ovf), 0);
    press_inc();
    chk("wrap_digits", int'(digits), 0);

    // Clear priority: count to 0o15, then clear and increment together.
    for (int i = 0; i < 13; i++) press_inc();
    chk("pre_clr_15", int'(digits), 6'o15);
    model = 0;
    press(1'b1, 1'b1, DB + 2, DB + 4, 1'b1, 6'o00, 1'b0, 1'b0);
    chk("clr_prio_digits", int'(digits), 0);
    press_inc();
    chk("after_clr_01", int'(digits), 6'o01);

    // Enable gating: press with en=0, raise en while still held.
    @(negedge clk);
    en = 1'b0;
    btn_inc = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);
    btn_inc = 1'b0;
    repeat (DB + 4) @(negedge clk);
    chk("en_gated_digits", int'(digits), 6'o01);
    press_inc();
    chk("en_after_digits", int'(digits), 6'o02);

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
